// File: rtl/mdu.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Latency: MULT/MULTU/DIV/DIVU 33 cycles accept-to-result; MTHI/MTLO 0 extra cycles.
// Backpressure: busy is high from the cycle after accept until the result is written; start is ignored meanwhile.
//
// Ports: clk, rstn (async active-low) | start, mdop[2:0], A[31:0], B[31:0] request |
//        busy, done (one-cycle pulse after an iterative op writes HI/LO) | hi, lo architectural registers.
// Optional feature: define MDU_DIV_EN to build the divider; without it DIV/DIVU are ignored like mdop 11x.
module mdu (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] wh;       // product high half / partial remainder
  logic [31:0] wl;       // multiplier then product low half / dividend then quotient
  logic [31:0] dv;       // multiplicand or divisor magnitude
  logic        neg_lo;   // negate product or quotient at FIX

  logic        sgn;
  logic        op_mul, op_div, op_mthi, op_mtlo;
  logic        accept, mthi_wr, mtlo_wr, fix;
  logic [31:0] a_mag, b_mag;
  logic [32:0] sum33;
  logic [63:0] prod_fix;

`ifdef MDU_DIV_EN
  logic        is_div;
  logic        neg_hi;   // remainder follows the dividend's sign
  logic        div0;
  logic [32:0] trial;
`endif

  // MULT and DIV are the signed variants (mdop[0] == 0).
  assign sgn     = ~mdop[0];
  assign op_mul  = start && (mdop[2:1] == 2'b00);
`ifdef MDU_DIV_EN
  assign op_div  = start && (mdop[2:1] == 2'b01);
`else
  assign op_div  = 1'b0;
`endif
  assign op_mthi = start && (mdop == 3'b100);
  assign op_mtlo = start && (mdop == 3'b101);

  assign a_mag = (sgn && A[31]) ? (32'd0 - A) : A;
  assign b_mag = (sgn && B[31]) ? (32'd0 - B) : B;

  assign sum33    = {1'b0, wh} + {1'b0, dv};
  assign prod_fix = neg_lo ? (64'd0 - {wh, wl}) : {wh, wl};
`ifdef MDU_DIV_EN
  assign trial    = {wh, wl[31]} - {1'b0, dv};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mthi_wr   = 1'b0;
    mtlo_wr   = 1'b0;
    fix       = 1'b0;
    case (state)
      IDLE: begin
        mthi_wr = op_mthi;
        mtlo_wr = op_mtlo;
        if (op_mul || op_div) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: if (cnt == 5'd31) state_nxt = FIX;
      FIX: begin
        fix       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Work registers: operands are stored as magnitudes, sign fixed once at FIX.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      wh     <= '0;
      wl     <= '0;
      dv     <= '0;
      neg_lo <= 1'b0;
`ifdef MDU_DIV_EN
      is_div <= 1'b0;
      neg_hi <= 1'b0;
      div0   <= 1'b0;
`endif
    end else if (accept) begin
      cnt    <= '0;
      wh     <= '0;
      wl     <= a_mag;
      dv     <= b_mag;
      neg_lo <= sgn && (A[31] ^ B[31]);
`ifdef MDU_DIV_EN
      is_div <= mdop[1];
      neg_hi <= sgn && A[31];
      div0   <= (B == 32'd0);
`endif
    end else if (state == CALC) begin
      cnt <= cnt + 5'd1;
`ifdef MDU_DIV_EN
      if (is_div) begin
        // Restoring step; a divisor of zero never "fails", so wh simply
        // shifts the dividend magnitude back in, which FIX relies on.
        if (!trial[32]) begin
          wh <= trial[31:0];
          wl <= {wl[30:0], 1'b1};
        end else begin
          wh <= {wh[30:0], wl[31]};
          wl <= {wl[30:0], 1'b0};
        end
      end else
`endif
      begin
        if (wl[0]) {wh, wl} <= {sum33, wl[31:1]};
        else       {wh, wl} <= {1'b0, wh, wl[31:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi   <= '0;
      lo   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= fix;
      if (mthi_wr) hi <= A;
      if (mtlo_wr) lo <= A;
      if (fix) begin
`ifdef MDU_DIV_EN
        if (is_div) begin
          // Divide by zero: wh holds |A| and neg_hi restores A's sign, giving A back.
          hi <= neg_hi ? (32'd0 - wh) : wh;
          lo <= div0 ? 32'hFFFF_FFFF : (neg_lo ? (32'd0 - wl) : wl);
        end else
`endif
        begin
          hi <= prod_fix[63:32];
          lo <= prod_fix[31:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

  logic        clk, rstn, start;
  logic [2:0]  mdop;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] hi, lo;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  mdu dut (
    .clk(clk), .rstn(rstn), .start(start), .mdop(mdop), .A(A), .B(B),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_hi, exp_lo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic bit is_iter(input logic [2:0] op);
    return (op[2:1] == 2'b00) || (DIV_EN && op[2:1] == 2'b01);
  endfunction

  // Architectural reference: {hi, lo} after the op, from plain arithmetic.
  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] ohi, input logic [31:0] olo);
    longint x, y, q, r;
    logic [63:0] res;
    res = {ohi, olo};
    case (op)
      3'd0: begin
        x = longint'($signed(a)); y = longint'($signed(b));
        res = 64'(x * y);
      end
      3'd1: res = {32'd0, a} * {32'd0, b};
      3'd2, 3'd3: if (DIV_EN) begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          if (op == 3'd2) begin x = longint'($signed(a)); y = longint'($signed(b)); end
          else            begin x = longint'({32'd0, a}); y = longint'({32'd0, b}); end
          q = x / y; r = x % y;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd4: res = {a, olo};
      3'd5: res = {ohi, a};
      default: ;
    endcase
    return res;
  endfunction

  // Issue one op and watch 36 cycles. restart_at >= 0 fires a MULT start sampled at that edge.
  task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int restart_at);
    int busy_cyc, done_cnt, done_at, res_k;
    bit held;
    logic [31:0] got_hi, got_lo;
    busy_cyc = 0; done_cnt = 0; done_at = -1; held = 1'b1;
    got_hi = 'x; got_lo = 'x;
    res_k = is_iter(op) ? 33 : 0;
    @(negedge clk);
    start = 1'b1; mdop = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;  // operands must already be latched
    for (int k = 0; k < 36; k++) begin
      if (busy) busy_cyc++;
      if (done) begin done_cnt++; done_at = k; end
      if (k < res_k && (hi !== exp_hi || lo !== exp_lo)) held = 1'b0;
      if (k == res_k) begin got_hi = hi; got_lo = lo; end
      if (restart_at >= 0 && k == restart_at - 1) begin
        start = 1'b1; mdop = 3'b000; A = 32'd3; B = 32'd5;
      end
      if (restart_at >= 0 && k == restart_at) start = 1'b0;
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, busy_cyc, is_iter(op) ? 33 : 0);
    chk({nm, " done_count"}, done_cnt, is_iter(op) ? 1 : 0);
    if (is_iter(op)) begin
      chk({nm, " done_cycle"}, done_at, 33);
      chk({nm, " hilo_held"}, {31'd0, held}, 32'd1);
    end
    chk({nm, " hi"}, got_hi, ehi);
    chk({nm, " lo"}, got_lo, elo);
    exp_hi = ehi; exp_lo = elo;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, ehi, elo;
  } vec_t;

  vec_t vecs[11];
  logic [63:0] r;
  logic [2:0]  rop;
  logic [31:0] ra, rb;
  int dcnt;

  initial begin
    vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5]  = '{3'd4, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'd0};
    vecs[6]  = '{3'd5, 32'hCAFE_BABE, 32'd9,         32'h1234_5678, 32'hCAFE_BABE};
    vecs[7]  = '{3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[8]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    vecs[9]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[10] = '{3'd6, 32'hDEAD_BEEF, 32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF};

    rstn = 1'b0; start = 1'b0; mdop = 3'd0; A = '0; B = '0;
    exp_hi = '0; exp_lo = '0;
    #12;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    @(negedge clk); rstn = 1'b1;

    // Table vectors. MTLO keeps hi from the preceding MTHI; ignored ops keep the prior state,
    // as do DIV/DIVU when the divider is not built.
    for (int i = 0; i < 11; i++) begin
      vec_t v;
      v = vecs[i];
      if (v.op == 3'd5) v.ehi = exp_hi;
      if (v.op == 3'd4) v.elo = exp_lo;
      if (v.op[2:1] == 2'b11 || (!DIV_EN && v.op[2:1] == 2'b01)) begin
        v.ehi = exp_hi; v.elo = exp_lo;
      end
      do_op($sformatf("vec%0d", i), v.op, v.a, v.b, v.ehi, v.elo, -1);
    end

    // A MULT start sampled at edge 5 of a running op must be dropped.
    if (DIV_EN) do_op("restart_div", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 5);
    else        do_op("restart_mulu", 3'd1, 32'h0001_0000, 32'h0003_0000, 32'd3, 32'd0, 5);

    // Randomized ops against the reference.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      r = ref_op(rop, ra, rb, exp_hi, exp_lo);
      do_op($sformatf("rand%0d", i), rop, ra, rb, r[63:32], r[31:0], -1);
    end

    // Asynchronous reset in the middle of a MULT, with nonzero HI/LO beforehand.
    do_op("pre_mthi", 3'd4, 32'h1111_1111, 32'd0, 32'h1111_1111, exp_lo, -1);
    do_op("pre_mtlo", 3'd5, 32'h2222_2222, 32'd0, 32'h1111_1111, 32'h2222_2222, -1);
    @(negedge clk); start = 1'b1; mdop = 3'd0; A = 32'd5; B = 32'd6;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset done", {31'd0, done}, 32'd0);
    chk("midreset hi", hi, 32'd0);
    chk("midreset lo", lo, 32'd0);
    @(negedge clk); rstn = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("postreset activity", dcnt, 0);
    chk("postreset hi", hi, 32'd0);
    chk("postreset lo", lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
